btn_debounce_pulse: RTL

Conditions a raw, asynchronous push-button (btnD on the board) into clean, single-cycle event pulses.
- Sits directly upstream of the scroll FSM that drives scrollMux16/dispHex16. Each press advances the displayed 16-bit window exactly once.
- Holding the button auto-repeats the advance at a fixed rate.
- Adds synchronisation, debounce, press/release edge detection and a hold-to-repeat state machine.

---
 rtl/btn_debounce_pulse_pkg.sv | 13 +
 rtl/btn_debounce_pulse_sync_debounce.sv | 55 +++++
 rtl/btn_debounce_pulse.sv | 103 ++++++++++
 3 files changed

// File: rtl/btn_debounce_pulse_pkg.sv
// Shared encodings and width helper for the button debounce / repeat-pulse block.
package btn_debounce_pulse_pkg;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_HOLD_DELAY  = 2'd1;
  localparam logic [1:0] ST_HOLD_REPEAT = 2'd2;

  // Bits needed to hold values 0..max_val inclusive (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_debounce.sv
// Two-flop synchroniser followed by a stable-sample debounce counter.
module btn_debounce_pulse_sync_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_flip
);
  import btn_debounce_pulse_pkg::*;

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            level_q, level_d;
  logic            flip;

  always_comb begin
    cnt_inc = cnt_q + CntOne;
    cnt_d   = '0;
    flip    = 1'b0;
    if (s2_q != level_q) begin
      // Reaching the threshold accepts the new level; counter restarts for the next change.
      if (cnt_inc == CntMax) begin
        flip = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    level_d = level_q ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign btn_level = level_q;
  // Combinational strobe: btn_level changes at the coming edge.
  assign btn_flip  = flip;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounced push-button with registered press/release pulses and hold-to-repeat.
module btn_debounce_pulse #(
  parameter int unsigned DB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  import btn_debounce_pulse_pkg::*;

  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmrW   = cnt_width(TmrMax);
  localparam logic [TmrW-1:0] TmrDelay = TmrW'(REPEAT_DELAY);
  localparam logic [TmrW-1:0] TmrRate  = TmrW'(REPEAT_RATE);
  localparam logic [TmrW-1:0] TmrOne   = TmrW'(1);

  logic            level, flip, rise, fall;
  logic [1:0]      state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            press_q, press_d, release_q, release_d;

  btn_debounce_pulse_sync_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sync_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(level),
    .btn_flip (flip)
  );

  assign rise = flip & ~level;
  assign fall = flip & level;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_HOLD_DELAY: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          timer_d   = '0;
        end else if (REPEAT_EN != 0 && timer_q == TmrDelay) begin
          press_d = 1'b1;
          timer_d = TmrOne;
          state_d = ST_HOLD_REPEAT;
        end else if (timer_q != TmrDelay) begin
          timer_d = timer_q + TmrOne;
        end
      end
      ST_HOLD_REPEAT: begin
        // A release wins over a repeat that falls due in the same cycle.
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          timer_d   = '0;
        end else if (timer_q == TmrRate) begin
          press_d = 1'b1;
          timer_d = TmrOne;
        end else begin
          timer_d = timer_q + TmrOne;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = ST_HOLD_DELAY;
          timer_d = TmrOne;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
